// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, memory depth and data memory FSM states.
package cpu_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 8;
   localparam int MEM_DEPTH = 256;
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: 256x8 storage, one write port and one registered read port.
module data_mem_array
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   // clr only clears the read register; stored contents survive reset
   always_ff @(posedge clk) begin
      if (clr) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/data_mem.sv
// data_mem: fixed-latency serialized load/store memory controller.
// DATA_MEM_STATS_EN adds saturating LoadCnt/StoreCnt completion counters.
module data_mem
   import cpu_pkg::*;
#(
   parameter int LATENCY = 2
)
(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Req,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] DataOut
`ifdef DATA_MEM_STATS_EN
   ,
   output logic [15:0]       LoadCnt,
   output logic [15:0]       StoreCnt
`endif
);
   state_t state, nxt;
   logic [3:0] cnt, cnt_nxt;
   logic wr_l, fin;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] din_l;
   always_comb begin
      nxt = state;
      cnt_nxt = cnt;
      case (state)
         IDLE: if (Req) begin
            nxt = WAIT;
            cnt_nxt = 4'(LATENCY - 1);
         end
         WAIT: if (cnt == 4'd0) nxt = DONE; else cnt_nxt = cnt - 4'd1;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt <= 4'd0;
      end else begin
         state <= nxt;
         cnt <= cnt_nxt;
      end
   end
   always_ff @(posedge Clk) begin
      if (state == IDLE && Req) begin
         wr_l <= WrEn;
         addr_l <= Addr;
         din_l <= DataIn;
      end
   end
   // completion edge; gated by reset so an aborted access leaves no trace
   assign fin = Reset_n && state == WAIT && cnt == 4'd0;
   assign Busy = state != IDLE;
   assign Done = state == DONE;
   data_mem_array u_array (
      .clk(Clk),
      .clr(!Reset_n),
      .we(fin && wr_l),
      .waddr(addr_l),
      .wdata(din_l),
      .re(fin && !wr_l),
      .raddr(addr_l),
      .rdata(DataOut)
   );
`ifdef DATA_MEM_STATS_EN
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         LoadCnt <= 16'd0;
         StoreCnt <= 16'd0;
      end else begin
         if (fin && !wr_l && LoadCnt != 16'hFFFF) LoadCnt <= LoadCnt + 16'd1;
         if (fin && wr_l && StoreCnt != 16'hFFFF) StoreCnt <= StoreCnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: randomized self-checking bench for data_mem against an array model.
module tb_data_mem;
   localparam int LAT = 2;
   logic Clk = 0, Reset_n = 0, Req = 0, WrEn = 0;
   logic [7:0] Addr = 0, DataIn = 0;
   logic Busy, Done;
   logic [7:0] DataOut;
`ifdef DATA_MEM_STATS_EN
   logic [15:0] LoadCnt, StoreCnt;
`endif
   int n_cmp = 0, n_err = 0;
   logic [7:0] mem_m [256];
   bit valid [256];
   logic [7:0] dout_m = 8'h00;

   always #5 Clk = ~Clk;

   data_mem #(.LATENCY(LAT)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .WrEn(WrEn), .Addr(Addr), .DataIn(DataIn),
      .Busy(Busy), .Done(Done), .DataOut(DataOut)
`ifdef DATA_MEM_STATS_EN
      , .LoadCnt(LoadCnt), .StoreCnt(StoreCnt)
`endif
   );

   // one request; inputs scrambled after accept, expected Done on the (LAT+1)th falling edge
   task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d);
      int n;
      bit busy_ok;
      @(negedge Clk);
      Req = 1; WrEn = wr; Addr = a; DataIn = d;
      @(negedge Clk);
      Req = 0; WrEn = 1'($urandom); Addr = 8'($urandom); DataIn = 8'($urandom);
      n = 1;
      busy_ok = (Busy === 1'b1);
      while (Done !== 1'b1 && n < 40) begin
         @(negedge Clk);
         n++;
         busy_ok = busy_ok && (Busy === 1'b1);
         WrEn = 1'($urandom); Addr = 8'($urandom); DataIn = 8'($urandom);
      end
      if (wr) begin
         mem_m[a] = d;
         valid[a] = 1;
      end else dout_m = mem_m[a];
      n_cmp++;
      if (n !== LAT + 1) begin n_err++; $display("FAIL latency addr=%h: got %0d cycles, need %0d", a, n, LAT + 1); end
      n_cmp++;
      if (!busy_ok) begin n_err++; $display("FAIL busy addr=%h: got Busy low during access, need high", a); end
      n_cmp++;
      if (DataOut !== dout_m) begin n_err++; $display("FAIL dataout wr=%0b addr=%h: got %h, need %h", wr, a, DataOut, dout_m); end
      @(negedge Clk);
      n_cmp++;
      if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL idle after done: got %b, need 00", {Busy, Done}); end
   endtask

   task automatic test_reset;
      Reset_n = 0; Req = 1; WrEn = 1; Addr = 8'h55; DataIn = 8'($urandom);
      repeat (3) @(negedge Clk);
      n_cmp++;
      if (Busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b, need 0", Busy); end
      n_cmp++;
      if (Done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b, need 0", Done); end
      n_cmp++;
      if (DataOut !== 8'h00) begin n_err++; $display("FAIL reset dataout: got %h, need 00", DataOut); end
      Reset_n = 1; Req = 0;
      @(negedge Clk);
      n_cmp++;
      if (Busy !== 1'b0) begin n_err++; $display("FAIL req during reset: got Busy %b, need 0", Busy); end
      dout_m = 8'h00;
   endtask

   task automatic test_store_load;
      access(1, 8'h10, 8'hA5);
      access(0, 8'h10, 8'h00);
      access(1, 8'h20, 8'($urandom));
   endtask

   task automatic test_back_to_back;
      int n;
      access(1, 8'h30, 8'($urandom));
      access(1, 8'h31, 8'($urandom));
      @(negedge Clk);
      Req = 1; WrEn = 0; Addr = 8'h30;
      @(negedge Clk);
      WrEn = 1; Addr = 8'h31; DataIn = ~mem_m[8'h31];
      n = 1;
      while (Done !== 1'b1 && n < 40) begin @(negedge Clk); n++; end
      dout_m = mem_m[8'h30];
      n_cmp++;
      if (n !== LAT + 1) begin n_err++; $display("FAIL b2b first latency: got %0d, need %0d", n, LAT + 1); end
      n_cmp++;
      if (DataOut !== dout_m) begin n_err++; $display("FAIL b2b first data: got %h, need %h", DataOut, dout_m); end
      WrEn = 0;
      @(negedge Clk);
      n_cmp++;
      if (Busy !== 1'b0) begin n_err++; $display("FAIL b2b idle gap: got Busy %b, need 0", Busy); end
      @(negedge Clk);
      n_cmp++;
      if (Busy !== 1'b1) begin n_err++; $display("FAIL b2b second accept: got Busy %b, need 1", Busy); end
      Req = 0;
      n = 1;
      while (Done !== 1'b1 && n < 40) begin @(negedge Clk); n++; end
      dout_m = mem_m[8'h31];
      n_cmp++;
      if (n !== LAT + 1) begin n_err++; $display("FAIL b2b second latency: got %0d, need %0d", n, LAT + 1); end
      n_cmp++;
      if (DataOut !== dout_m) begin n_err++; $display("FAIL b2b second data: got %h, need %h", DataOut, dout_m); end
      @(negedge Clk);
   endtask

   task automatic test_reset_mid;
      logic [7:0] v_old;
      v_old = 8'($urandom_range(1, 59));
      access(1, 8'hFF, v_old);
      access(0, 8'hFF, 8'h00);
      @(negedge Clk);
      Req = 1; WrEn = 1; Addr = 8'hFF; DataIn = 8'h3C;
      @(negedge Clk);
      Req = 0; Reset_n = 0;
      @(negedge Clk);
      Reset_n = 1;
      dout_m = 8'h00;
      n_cmp++;
      if ({Busy, Done} !== 2'b00) begin n_err++; $display("FAIL abort busy/done: got %b, need 00", {Busy, Done}); end
      n_cmp++;
      if (DataOut !== 8'h00) begin n_err++; $display("FAIL abort dataout: got %h, need 00", DataOut); end
      @(negedge Clk);
      n_cmp++;
      if (Done !== 1'b0) begin n_err++; $display("FAIL abort late done: got %b, need 0", Done); end
      access(0, 8'hFF, 8'h00);
   endtask

   task automatic test_bounds;
      logic [7:0] a;
      a = 8'($urandom);
      access(1, 8'h00, a);
      access(1, 8'hFF, ~a);
      access(0, 8'h00, 8'h00);
      access(0, 8'hFF, 8'h00);
   endtask

   task automatic test_random;
      logic [7:0] pool [8];
      logic [7:0] a;
      bit wr;
      foreach (pool[i]) pool[i] = 8'($urandom);
      repeat (20) begin
         a = pool[$urandom_range(0, 7)];
         wr = !valid[a] || ($urandom % 2 == 0);
         access(wr, a, 8'($urandom));
      end
   endtask

`ifdef DATA_MEM_STATS_EN
   task automatic test_stats;
      @(negedge Clk);
      Reset_n = 0;
      @(negedge Clk);
      Reset_n = 1;
      dout_m = 8'h00;
      n_cmp++;
      if ({LoadCnt, StoreCnt} !== 32'h0) begin n_err++; $display("FAIL stats reset: got %h/%h, need 0/0", LoadCnt, StoreCnt); end
      access(1, 8'h40, 8'($urandom));
      access(0, 8'h40, 8'h00);
      access(1, 8'h41, 8'($urandom));
      access(0, 8'h41, 8'h00);
      access(0, 8'h40, 8'h00);
      n_cmp++;
      if (LoadCnt !== 16'd3) begin n_err++; $display("FAIL loadcnt: got %0d, need 3", LoadCnt); end
      n_cmp++;
      if (StoreCnt !== 16'd2) begin n_err++; $display("FAIL storecnt: got %0d, need 2", StoreCnt); end
      force dut.LoadCnt = 16'hFFFF;
      @(negedge Clk);
      release dut.LoadCnt;
      access(0, 8'h40, 8'h00);
      n_cmp++;
      if (LoadCnt !== 16'hFFFF) begin n_err++; $display("FAIL loadcnt saturate: got %h, need ffff", LoadCnt); end
      n_cmp++;
      if (StoreCnt !== 16'd2) begin n_err++; $display("FAIL storecnt hold: got %0d, need 2", StoreCnt); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_store_load;
      test_back_to_back;
      test_reset_mid;
      test_bounds;
      test_random;
`ifdef DATA_MEM_STATS_EN
      test_stats;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 The module SHALL have parameter LATENCY, default 2, meaning wait cycles from request accept to completion (legal range 1..15).
REQ-002 The module SHALL have port Clk  input  1  rising-edge clock, the only clock.
REQ-003 The module SHALL have port Reset_n  input  1  synchronous active-low reset.
REQ-004 The module SHALL have port Req  input  1  access request, sampled only while Busy is low.
REQ-005 The module SHALL have port WrEn  input  1  1 = store, 0 = load, sampled with Req.
REQ-006 The module SHALL have port Addr  input  8  byte address, sampled with Req.
REQ-007 The module SHALL have port DataIn  input  8  store data, sampled with Req.
REQ-008 The module SHALL have port Busy  output  1  access in progress; new requests ignored.
REQ-009 The module SHALL have port Done  output  1  one-cycle completion pulse for a load or a store.
REQ-010 The module SHALL have port DataOut  output  8  last completed load data; feeds the writeback select memory input.

Function
REQ-011 Storage SHALL be 256 x 8 bits, and the full 8-bit address space SHALL be valid, with no out-of-range case.
REQ-012 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-013 IDLE SHALL go to WAIT on a Clk edge with Req = 1, latching WrEn, Addr and DataIn into internal registers.
REQ-014 WAIT SHALL load a down-counter with LATENCY-1 on entry and SHALL go to DONE on the edge where the counter equals 0.
REQ-015 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-016 Busy SHALL equal (state != IDLE), so Busy is high in WAIT and DONE.
REQ-017 Done SHALL equal (state == DONE).
REQ-018 A request SHALL be accepted at edge k, and Done SHALL be high in the cycle after edge k+LATENCY.
REQ-019 A store SHALL write the latched DataIn to the latched Addr on the WAIT->DONE edge.
REQ-020 A load SHALL update DataOut from the latched Addr on the WAIT->DONE edge, so DataOut is valid while Done is high.
REQ-021 DataOut SHALL hold its value across stores and idle cycles and SHALL change only on load completion.
REQ-022 Req while Busy is high, including the DONE cycle, SHALL be ignored with no queueing; the master re-requests after Done.
REQ-023 Changes to Addr, DataIn or WrEn after accept SHALL have no effect on the access in flight.
REQ-024 A load from an address written earlier SHALL return the stored value; read-after-write SHALL need no forwarding because accesses are serialized.

Reset
REQ-025 Reset_n low at a Clk edge SHALL force state IDLE, Busy = 0, Done = 0, DataOut = 8'h00 and the counter to 0.
REQ-026 Reset mid-access SHALL abort the access: a pending store SHALL NOT be written and a pending load SHALL NOT update DataOut.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 Req SHALL be ignored in any cycle where Reset_n is low.

Configuration
REQ-029 Macro DATA_MEM_STATS_EN SHALL control an access statistics feature.
REQ-030 With DATA_MEM_STATS_EN defined, the module SHALL add outputs LoadCnt[15:0] and StoreCnt[15:0].
REQ-031 Each counter SHALL increment on completion (DONE) of its access type, SHALL saturate at 16'hFFFF, and SHALL reset to 0.
REQ-032 Without DATA_MEM_STATS_EN, the counter ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Shared package cpu_pkg SHALL hold DATA_W = 8, ADDR_W = 8, MEM_DEPTH = 256 and the FSM state enum (IDLE/WAIT/DONE).
REQ-034 The storage array SHALL be the single sub-module data_mem_array (1 write port, 1 synchronous read port), with the FSM, latches and counters in data_mem.

Verification
REQ-035 The bench SHALL cover: with LATENCY = 2, store Addr = 8'h10, DataIn = 8'hA5 at edge 0 -> Busy high for cycles 1-3, Done only in cycle 3, DataOut unchanged.
REQ-036 The bench SHALL cover: load Addr = 8'h10 after that store -> Done 3 cycles after accept with DataOut = 8'hA5, and DataOut holds 8'hA5 through a later store to 8'h20.
REQ-037 The bench SHALL cover: Req held high continuously with different Addr during Busy -> only the first request executes, and the next is accepted in the cycle after Done.
REQ-038 The bench SHALL cover: Reset_n low during WAIT of a store of 8'h3C to 8'hFF -> Busy/Done/DataOut = 0/0/8'h00 next cycle, and a later load of 8'hFF returns the old value.
REQ-039 The bench SHALL cover: addresses 8'h00 and 8'hFF each written and read back -> correct data, with no aliasing.
REQ-040 With DATA_MEM_STATS_EN, the bench SHALL run 3 loads and 2 stores -> LoadCnt = 3, StoreCnt = 2, and a counter forced to 16'hFFFF stays at 16'hFFFF after a further access.
